// File: rtl/lift_pkg.sv
// Shared types and default sizing for the lift controller.
// Latency: n/a. Backpressure: n/a.
package lift_pkg;

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_IDLE       = 3'd1,
    S_MOVING     = 3'd2,
    S_DOOR_OPEN  = 3'd3,
    S_DOOR_CLOSE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  localparam int DEF_NUM_FLOORS  = 16;
  localparam int DEF_MOVE_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES = 8;
  localparam int DEF_WEIGHT_W    = 10;
  localparam int DEF_MAX_WEIGHT  = 700;

endpackage

// File: rtl/lift_ctrl_if.sv
// Cabin/landing signal bundle between the lift controller and its surroundings.
// Latency: n/a. Backpressure: none, all signals are levels or pulses.
interface lift_ctrl_if #(
  parameter int NUM_FLOORS = 16,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS),
  parameter int WEIGHT_W   = 10
);
  logic                  i_power;
  logic                  i_battery;
  logic [NUM_FLOORS-1:0] i_hall_up;
  logic [NUM_FLOORS-1:0] i_hall_down;
  logic [NUM_FLOORS-1:0] i_car_call;
  logic                  i_open;
  logic                  i_close;
  logic [WEIGHT_W-1:0]   i_weight;
  logic [FLOOR_W-1:0]    o_floor;
  logic [1:0]            o_dir;
  logic                  o_moving;
  logic                  o_open;
  logic                  o_close;
  logic                  o_overweight;
  logic [NUM_FLOORS-1:0] o_pending;

  modport master (
    output i_power, i_battery, i_hall_up, i_hall_down, i_car_call,
           i_open, i_close, i_weight,
    input  o_floor, o_dir, o_moving, o_open, o_close, o_overweight, o_pending
  );

  modport slave (
    input  i_power, i_battery, i_hall_up, i_hall_down, i_car_call,
           i_open, i_close, i_weight,
    output o_floor, o_dir, o_moving, o_open, o_close, o_overweight, o_pending
  );
endinterface

// File: rtl/lift_req_sched.sv
// Latched floor requests plus here/above/below flags relative to a probe floor.
// Latency: requests visible one cycle after the input. Backpressure: none.
module lift_req_sched
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr_all,
  input  logic                  i_accept,
  input  logic [NUM_FLOORS-1:0] i_hall_up,
  input  logic [NUM_FLOORS-1:0] i_hall_down,
  input  logic [NUM_FLOORS-1:0] i_car_call,
  input  logic                  i_clr_en,
  input  logic [FLOOR_W-1:0]    i_clr_floor,
  input  logic [FLOOR_W-1:0]    i_eval_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_here,
  output logic                  o_above,
  output logic                  o_below
);

  // No up call exists at the top landing, no down call at the bottom one.
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] req_vec;

  assign req_vec = i_car_call | (i_hall_up & UP_MASK) | (i_hall_down & DN_MASK);

  always_comb begin
    pending_d = pending_q;
    if (i_clr_all) begin
      pending_d = '0;
    end else begin
      if (i_accept) pending_d = pending_d | req_vec;
      if (i_clr_en) pending_d[i_clr_floor] = 1'b0;
    end
  end

  always_comb begin
    o_above = 1'b0;
    o_below = 1'b0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (pending_q[f] && (FLOOR_W'(f) > i_eval_floor)) o_above = 1'b1;
      if (pending_q[f] && (FLOOR_W'(f) < i_eval_floor)) o_below = 1'b1;
    end
    o_here = pending_q[i_eval_floor];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign o_pending = pending_q;

endmodule

// File: rtl/lift_ctrl.sv
// Single-car lift controller: request latching, travel sequencing, door dwell and load interlock.
// Latency: one transition per clock, MOVE_CYCLES per floor. Backpressure: none, inputs are sampled levels.
module lift_ctrl
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int FLOOR_W     = $clog2(NUM_FLOORS),
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES,
  parameter int WEIGHT_W    = DEF_WEIGHT_W,
  parameter int MAX_WEIGHT  = DEF_MAX_WEIGHT
) (
  input  logic     i_clk,
  input  logic     i_rst,
  lift_ctrl_if.slave bus
);

  localparam int MCNT_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int TMR_W  = $clog2(DOOR_CYCLES + 1);
  localparam logic [MCNT_W-1:0]   MOVE_LAST    = MCNT_W'(MOVE_CYCLES - 1);
  localparam logic [TMR_W-1:0]    DWELL        = TMR_W'(DOOR_CYCLES);
  localparam logic [TMR_W-1:0]    TMR_ONE      = TMR_W'(1);
  localparam logic [FLOOR_W-1:0]  TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [WEIGHT_W-1:0] WEIGHT_LIMIT = WEIGHT_W'(MAX_WEIGHT);

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic                last_up_q, last_up_d;
  logic [MCNT_W-1:0]   move_cnt_q, move_cnt_d;
  logic [TMR_W-1:0]    door_tmr_q, door_tmr_d;

  logic                powered, arrive, heavy, ahead, behind;
  logic [FLOOR_W-1:0]  next_floor, eval_floor;
  logic                here, above, below;
  logic                clr_en;

  assign powered = bus.i_power && bus.i_battery;
  assign arrive  = (state_q == S_MOVING) && (move_cnt_q == MOVE_LAST);
  assign heavy   = bus.i_weight > WEIGHT_LIMIT;

  always_comb begin
    next_floor = floor_q;
    if (dir_q == DIR_UP && floor_q != TOP_FLOOR)              next_floor = floor_q + 1'b1;
    else if (dir_q == DIR_DOWN && floor_q != '0)              next_floor = floor_q - 1'b1;
  end

  // On the arrival cycle the scheduler must judge the floor being reached, not the one left.
  assign eval_floor = arrive ? next_floor : floor_q;
  assign ahead      = (dir_q == DIR_UP) ? above : below;
  assign behind     = (dir_q == DIR_UP) ? below : above;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    floor_d    = floor_q;
    last_up_d  = last_up_q;
    move_cnt_d = move_cnt_q;
    door_tmr_d = door_tmr_q;
    if (!powered) begin
      state_d    = S_OFF;
      dir_d      = DIR_NONE;
      move_cnt_d = '0;
      door_tmr_d = '0;
    end else begin
      case (state_q)
        S_OFF: state_d = S_IDLE;
        S_IDLE: begin
          if (here) begin
            state_d    = S_DOOR_OPEN;
            door_tmr_d = DWELL;
          end else if (above && (!below || last_up_q)) begin
            state_d    = S_MOVING;
            dir_d      = DIR_UP;
            last_up_d  = 1'b1;
            move_cnt_d = '0;
          end else if (below) begin
            state_d    = S_MOVING;
            dir_d      = DIR_DOWN;
            last_up_d  = 1'b0;
            move_cnt_d = '0;
          end else begin
            dir_d = DIR_NONE;
          end
        end
        S_MOVING: begin
          if (!arrive) begin
            move_cnt_d = move_cnt_q + 1'b1;
          end else begin
            floor_d    = next_floor;
            move_cnt_d = '0;
            if (here) begin
              state_d    = S_DOOR_OPEN;
              door_tmr_d = DWELL;
            end else if (ahead) begin
              state_d = S_MOVING;
            end else if (behind) begin
              dir_d     = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
              last_up_d = (dir_q != DIR_UP);
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DOOR_OPEN: begin
          if (bus.i_open) begin
            door_tmr_d = DWELL;
          end else if (bus.i_close || door_tmr_q <= TMR_ONE) begin
            if (heavy) begin
              door_tmr_d = DWELL;
            end else begin
              state_d    = S_DOOR_CLOSE;
              door_tmr_d = '0;
            end
          end else begin
            door_tmr_d = door_tmr_q - 1'b1;
          end
        end
        S_DOOR_CLOSE: begin
          if (bus.i_open) begin
            state_d    = S_DOOR_OPEN;
            door_tmr_d = DWELL;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Calls for the landing the door is open at are absorbed rather than queued.
  assign clr_en = (state_d == S_DOOR_OPEN) || (state_q == S_DOOR_OPEN);

  lift_req_sched #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_sched (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr_all    (state_d == S_OFF),
    .i_accept     (state_q != S_OFF),
    .i_hall_up    (bus.i_hall_up),
    .i_hall_down  (bus.i_hall_down),
    .i_car_call   (bus.i_car_call),
    .i_clr_en     (clr_en),
    .i_clr_floor  (floor_d),
    .i_eval_floor (eval_floor),
    .o_pending    (bus.o_pending),
    .o_here       (here),
    .o_above      (above),
    .o_below      (below)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_OFF;
      dir_q      <= DIR_NONE;
      floor_q    <= '0;
      last_up_q  <= 1'b1;
      move_cnt_q <= '0;
      door_tmr_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      floor_q    <= floor_d;
      last_up_q  <= last_up_d;
      move_cnt_q <= move_cnt_d;
      door_tmr_q <= door_tmr_d;
    end
  end

  assign bus.o_floor      = floor_q;
  assign bus.o_dir        = dir_q;
  assign bus.o_moving     = (state_q == S_MOVING);
  assign bus.o_open       = (state_q == S_DOOR_OPEN);
  assign bus.o_close      = (state_q != S_DOOR_OPEN);
  assign bus.o_overweight = (state_q == S_DOOR_OPEN) && heavy;

endmodule

// File: doc/lift_ctrl.md
LIFT_CTRL -- requirements
Module: lift_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 16: number of served floors, range 2..32.
REQ-002 Parameter FLOOR_W, default $clog2(NUM_FLOORS): floor index width, derived.
REQ-003 Parameter MOVE_CYCLES, default 4: clock cycles to travel one floor, minimum 1.
REQ-004 Parameter DOOR_CYCLES, default 8: door dwell in cycles, minimum 1.
REQ-005 Parameter WEIGHT_W, default 10: load input width.
REQ-006 Parameter MAX_WEIGHT, default 700: highest load allowed to depart.
REQ-007 One clock, i_clk; reset i_rst, synchronous, active-high.
REQ-008 Ports, name direction width meaning:
- i_clk  in  1  clock.
- i_rst  in  1  sync reset, active-high.
- i_power  in  1  mains present.
- i_battery  in  1  battery healthy.
- i_hall_up  in  NUM_FLOORS  one-hot-per-floor up calls.
- i_hall_down  in  NUM_FLOORS  down calls.
- i_car_call  in  NUM_FLOORS  cabin destination buttons.
- i_open  in  1  door-open button.
- i_close  in  1  door-close button.
- i_weight  in  WEIGHT_W  cabin load, unsigned.
- o_floor  out  FLOOR_W  current floor.
- o_dir  out  2  00 none, 01 up, 10 down.
- o_moving  out  1  cabin travelling.
- o_open  out  1  door open.
- o_close  out  1  door closed.
- o_overweight  out  1  departure blocked by load.
- o_pending  out  NUM_FLOORS  latched requests.

Function
REQ-009 States OFF, IDLE, MOVING, DOOR_OPEN, DOOR_CLOSE; one transition per clock.
REQ-010 OFF->IDLE when i_power && i_battery; any state->OFF at next edge when either is low; pending cleared, o_floor held, o_open=0, o_close=1, o_moving=0.
REQ-011 Outside OFF, pending[f] sets on any of the three request inputs for f, one cycle after the input; bits accumulate.
REQ-012 i_hall_up[NUM_FLOORS-1] and i_hall_down[0] ignored.
REQ-013 IDLE: pending[o_floor] -> DOOR_OPEN; else pending above/below -> MOVING in that direction; if both, keep last o_dir (up after reset); none -> stay, o_dir=00.
REQ-014 MOVING: counter runs MOVE_CYCLES cycles, then o_floor +-1; if pending[new floor] -> DOOR_OPEN, else continue while pending remains ahead, else reverse if pending behind, else IDLE.
REQ-015 o_floor never wraps; clamped to 0..NUM_FLOORS-1.
REQ-016 DOOR_OPEN entry: pending[o_floor] cleared, dwell timer loaded DOOR_CYCLES, o_open=1, o_close=0.
REQ-017 In DOOR_OPEN, i_open reloads timer; i_close zeroes it; i_open wins when both high.
REQ-018 Timer zero and i_weight <= MAX_WEIGHT -> DOOR_CLOSE; i_weight > MAX_WEIGHT -> stay, o_overweight=1, timer reloads.
REQ-019 DOOR_CLOSE lasts one cycle, o_open=0, o_close=1, then IDLE; i_open during it -> back to DOOR_OPEN.
REQ-020 New request for the current floor arriving in DOOR_OPEN is cleared without reopening.
REQ-021 o_moving=1 only in MOVING; o_open and o_close never both 1.

Reset
REQ-022 i_rst: state OFF, o_floor=0, o_dir=00, o_moving=0, o_open=0, o_close=1, o_overweight=0, pending=0, counters=0, last direction up.
REQ-023 Reset mid-move or mid-dwell abandons the operation; no partial floor update.

Structure
REQ-024 Package lift_pkg holds state_e, dir_e, and default parameter constants.
REQ-025 Sub-module lift_req_sched holds the pending register and computes here/above/below flags.

Verification
REQ-026 Reset, power=battery=1, car_call[5] pulse at floor 0 -> o_floor reaches 5 after 5*MOVE_CYCLES+O(2) cycles, o_open=1, pending[5]=0.
REQ-027 At floor 3 moving up to 9: hall_down[1] and car_call[6] pulse -> stops at 6, then 9, then reverses to 1.
REQ-028 Door open, i_weight=701 -> o_overweight=1, door stays open; weight=650 -> DOOR_CLOSE within DOOR_CYCLES+1.
REQ-029 i_open held 20 cycles in DOOR_OPEN -> o_open=1 throughout; release -> closes DOOR_CYCLES later; i_close pulse -> closes next cycle.
REQ-030 i_battery dropped while MOVING at floor 4 -> OFF next cycle, o_floor=4, pending=0, o_close=1.
REQ-031 i_hall_up[15] and i_hall_down[0] pulses (NUM_FLOORS=16) -> pending unchanged, no motion.
